// File: rtl/logic_reg_pkg.sv
// Shared constants and types for logic_reg_unit: op encoding, FIFO depth and occupancy states.
package logic_reg_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam logic [1:0] DEPTH = 2'd2;

  // Encoding equals the number of stored entries, so it compares directly against DEPTH.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/logic_reg_unit_lane.sv
// One lane of the bitwise operation; purely combinational, registered by the parent FIFO.
module logic_lane
  import logic_reg_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  // Select the lane result for the requested operation.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_reg_unit.sv
// Registered CH-lane bitwise logic unit with a 2-entry result FIFO and valid/ready handshakes.
// Define LOGIC_REG_UNIT_PARITY_EN to add per-lane even parity stored with each result.
module logic_reg_unit
  import logic_reg_pkg::*;
#(
  parameter int W     = 4,
  parameter int CH    = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [CH*W-1:0]   a,
  input  logic [CH*W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH*W-1:0]   y,
  output logic [CNT_W-1:0]  done_cnt,
  output logic [CH-1:0]     all_ones
`ifdef LOGIC_REG_UNIT_PARITY_EN
  ,
  output logic [CH-1:0]     par
`endif
);

  occ_e              occ_r;
  occ_e              occ_nxt;
  logic [CH*W-1:0]   result_s;
  logic [CH*W-1:0]   head_r;
  logic [CH*W-1:0]   tail_r;
  logic [CNT_W-1:0]  done_cnt_r;
  logic              push_s;
  logic              pop_s;
  logic              load_head_s;
  logic              load_tail_s;
  logic              shift_s;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    logic_lane #(.W(W)) u_lane (
      .op (op),
      .a  (a[k*W +: W]),
      .b  (b[k*W +: W]),
      .y  (result_s[k*W +: W])
    );
  end

  // Handshake flags come from registered occupancy only, never from out_ready.
  assign in_ready  = (occ_r < DEPTH);
  assign out_valid = (occ_r != OCC_EMPTY);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r <= OCC_EMPTY;
    end else begin
      occ_r <= occ_nxt;
    end
  end

  // Next occupancy and FIFO write controls.
  always_comb begin
    occ_nxt     = occ_r;
    load_head_s = 1'b0;
    load_tail_s = 1'b0;
    shift_s     = 1'b0;
    case (occ_r)
      OCC_EMPTY: begin
        if (push_s) begin
          occ_nxt     = OCC_ONE;
          load_head_s = 1'b1;
        end else begin
          occ_nxt = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (push_s && pop_s) begin
          // Head leaves and the new result takes its place in the same edge.
          occ_nxt     = OCC_ONE;
          load_head_s = 1'b1;
        end else if (push_s) begin
          occ_nxt     = OCC_FULL;
          load_tail_s = 1'b1;
        end else if (pop_s) begin
          occ_nxt = OCC_EMPTY;
        end else begin
          occ_nxt = OCC_ONE;
        end
      end
      OCC_FULL: begin
        if (pop_s) begin
          occ_nxt = OCC_ONE;
          shift_s = 1'b1;
        end else begin
          occ_nxt = OCC_FULL;
        end
      end
      default: begin
        occ_nxt = OCC_EMPTY;
      end
    endcase
  end

  // FIFO data storage; head is the visible result and keeps its value after draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= '0;
      tail_r <= '0;
    end else begin
      if (load_head_s) begin
        head_r <= result_s;
      end else if (shift_s) begin
        head_r <= tail_r;
      end
      if (load_tail_s) begin
        tail_r <= result_s;
      end
    end
  end

  // Completed-transaction counter, wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_r <= '0;
    end else if (pop_s) begin
      done_cnt_r <= done_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign y        = head_r;
  assign done_cnt = done_cnt_r;

  // Per-lane all-ones flag of the head, forced low when nothing is held.
  always_comb begin
    all_ones = '0;
    for (int k = 0; k < CH; k++) begin
      all_ones[k] = out_valid & (&head_r[k*W +: W]);
    end
  end

`ifdef LOGIC_REG_UNIT_PARITY_EN
  logic [CH-1:0] result_par_s;
  logic [CH-1:0] head_par_r;
  logic [CH-1:0] tail_par_r;

  // Parity is computed once at push and travels with the data.
  always_comb begin
    result_par_s = '0;
    for (int k = 0; k < CH; k++) begin
      result_par_s[k] = ^result_s[k*W +: W];
    end
  end

  // Parity storage mirrors the data entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_par_r <= '0;
      tail_par_r <= '0;
    end else begin
      if (load_head_s) begin
        head_par_r <= result_par_s;
      end else if (shift_s) begin
        head_par_r <= tail_par_r;
      end
      if (load_tail_s) begin
        tail_par_r <= result_par_s;
      end
    end
  end

  assign par = out_valid ? head_par_r : '0;
`endif

endmodule

// File: tb/tb_logic_reg_unit.sv
// Randomized and directed self-checking bench for logic_reg_unit against a queue-based model.
module tb_logic_reg_unit;

  localparam int W     = 4;
  localparam int CH    = 2;
  localparam int CNT_W = 8;
  localparam int BW    = CH * W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [BW-1:0]     a;
  logic [BW-1:0]     b;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     y;
  logic [CNT_W-1:0]  done_cnt;
  logic [CH-1:0]     all_ones;
`ifdef LOGIC_REG_UNIT_PARITY_EN
  logic [CH-1:0]     par;
`endif

  logic_reg_unit #(.W(W), .CH(CH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .done_cnt  (done_cnt),
    .all_ones  (all_ones)
`ifdef LOGIC_REG_UNIT_PARITY_EN
    ,
    .par       (par)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [BW-1:0]    q[$];
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] model_op(input logic [1:0] o, input logic [BW-1:0] x, input logic [BW-1:0] z);
    case (o)
      2'd0:    return x & z;
      2'd1:    return x | z;
      2'd2:    return x ^ z;
      default: return ~(x & z);
    endcase
  endfunction

  function automatic logic [CH-1:0] lane_ones(input logic [BW-1:0] v);
    logic [CH-1:0] r;
    for (int k = 0; k < CH; k++) r[k] = (v[k*W +: W] == {W{1'b1}});
    return r;
  endfunction

  function automatic logic [CH-1:0] lane_par(input logic [BW-1:0] v);
    logic [CH-1:0] r;
    for (int k = 0; k < CH; k++) r[k] = ^v[k*W +: W];
    return r;
  endfunction

  task automatic check_outputs();
    check_val("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check_val("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check_val("done_cnt", 32'(done_cnt), 32'(m_cnt));
    if (q.size() != 0) begin
      check_val("y", 32'(y), 32'(q[0]));
      check_val("all_ones", 32'(all_ones), 32'(lane_ones(q[0])));
`ifdef LOGIC_REG_UNIT_PARITY_EN
      check_val("par", 32'(par), 32'(lane_par(q[0])));
`endif
    end else begin
      check_val("all_ones_idle", 32'(all_ones), 32'd0);
`ifdef LOGIC_REG_UNIT_PARITY_EN
      check_val("par_idle", 32'(par), 32'd0);
`endif
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [BW-1:0] x, input logic [BW-1:0] z, input logic rdy);
    in_valid  = v;
    op        = o;
    a         = x;
    b         = z;
    out_ready = rdy;
  endtask

  // One clock: check before the edge, then advance the model with what the edge accepted.
  task automatic cycle();
    logic          push;
    logic          pop;
    logic [BW-1:0] r;
    @(negedge clk);
    check_outputs();
    push = in_valid && (q.size() < 2);
    pop  = (q.size() != 0) && out_ready;
    r    = model_op(op, a, b);
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      m_cnt++;
    end
    if (push) q.push_back(r);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, '0, '0, 1'b0);
    #22;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_y", 32'(y), 32'd0);
    check_val("rst_done_cnt", 32'(done_cnt), 32'd0);
    check_val("rst_all_ones", 32'(all_ones), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single AND push with a ready consumer.
    drive(1'b1, 2'd0, 8'hF3, 8'h5A, 1'b1);
    cycle();
    check_val("and_valid", 32'(out_valid), 32'd1);
    check_val("and_y", 32'(y), 32'h52);
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    cycle();
    check_val("and_drained", 32'(out_valid), 32'd0);
    check_val("and_cnt", 32'(done_cnt), 32'd1);

    // Back-pressure: fill the FIFO, reject a third beat, then drain.
    drive(1'b1, 2'd1, 8'h0F, 8'hF0, 1'b0);
    cycle();
    drive(1'b1, 2'd2, 8'hFF, 8'h0F, 1'b0);
    cycle();
    check_val("bp_y", 32'(y), 32'hFF);
    check_val("bp_ones", 32'(all_ones), 32'h3);
    check_val("bp_full", 32'(in_ready), 32'd0);
    drive(1'b1, 2'd0, 8'h11, 8'h22, 1'b0);
    cycle();
    check_val("bp_hold_y", 32'(y), 32'hFF);
    check_val("bp_still_full", 32'(in_ready), 32'd0);
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    cycle();
    check_val("bp_y2", 32'(y), 32'hF0);
    check_val("bp_ones2", 32'(all_ones), 32'h2);
    cycle();
    check_val("bp_empty", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at occupancy one.
    drive(1'b1, 2'd0, 8'hFF, 8'h0F, 1'b0);
    cycle();
    drive(1'b1, 2'd3, 8'hFF, 8'h00, 1'b1);
    cycle();
    check_val("pp_y", 32'(y), 32'hFF);
    check_val("pp_ready", 32'(in_ready), 32'd1);
    check_val("pp_cnt", 32'(done_cnt), 32'd4);
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    cycle();

`ifdef LOGIC_REG_UNIT_PARITY_EN
    drive(1'b1, 2'd2, 8'h17, 8'h00, 1'b0);
    cycle();
    check_val("par_xor", 32'(par), 32'h3);
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    cycle();
`endif

    // Random traffic; long enough for done_cnt to wrap.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 9) < 7), 2'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 9) < 6));
      cycle();
    end

    // Reset while full flushes both entries immediately.
    drive(1'b1, 2'd1, 8'h3C, 8'h41, 1'b0);
    cycle();
    cycle();
    cycle();
    check_val("pre_rst_full", 32'(in_ready), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_y", 32'(y), 32'd0);
    check_val("mid_rst_cnt", 32'(done_cnt), 32'd0);
    check_val("mid_rst_ready", 32'(in_ready), 32'd1);
    q.delete();
    m_cnt = '0;
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
